pi_so_shift_tx: RTL and testbench

//  Parallel-in serial-out transmitter; the sending end of the 8-bit serial link whose

---
 rtl/pi_so_shift_tx_pkg.sv | 13 +
 rtl/pi_so_shift_tx_bit_cnt.sv | 27 ++
 rtl/pi_so_shift_tx.sv | 91 +++++++++
 tb/tb_pi_so_shift_tx.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pi_so_shift_tx_pkg.sv
// Shared link definitions for the PISO transmitter and its SI/PO receiver peer.
// State encodings are fixed so waveforms line up with the receiver-side tooling.
package pi_so_shift_tx_pkg;

  localparam int LINK_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

endpackage

// File: rtl/pi_so_shift_tx_bit_cnt.sv
// Bit counter for the serialiser: sync clear wins over enable, holds at WIDTH-1 (tc).
// Latency: cnt/tc update one clk after clr/en; no backpressure.
module pi_so_shift_tx_bit_cnt #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  assign tc = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pi_so_shift_tx.sv
// Parallel-in serial-out link transmitter: bit i of an accepted word is on SO i+1 clks after acceptance,
// latch strobes WIDTH+1 clks after; ready only in IDLE/LATCH, load while busy is dropped.
module pi_so_shift_tx
  import pi_so_shift_tx_pkg::*;
#(
  parameter int WIDTH     = LINK_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             SO,
  output logic             so_valid,
  output logic             latch,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  state_e            state, state_nxt;
  logic [WIDTH-1:0]  shreg, shreg_nxt;
  logic              accept;
  logic              cnt_en;
  logic              tc;
  logic              head_nxt;
  logic [CW-1:0]     cnt;

  assign ready = (state == ST_IDLE) || (state == ST_LATCH);
  assign busy  = (state != ST_IDLE);

  pi_so_shift_tx_bit_cnt #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_cnt (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (cnt_en),
    .cnt (cnt),
    .tc  (tc)
  );

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    accept    = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        accept = load;
      end
      ST_SHIFT: begin
        cnt_en = 1'b1;
        if (MSB_FIRST) shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
        else           shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
        if (tc) state_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        accept    = load;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (accept) begin
      state_nxt = ST_SHIFT;
      shreg_nxt = din;
    end
  end

  // Outputs are computed from next state so SO/latch come straight off flops.
  assign head_nxt = MSB_FIRST ? shreg_nxt[WIDTH-1] : shreg_nxt[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      SO       <= 1'b0;
      so_valid <= 1'b0;
      latch    <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      so_valid <= (state_nxt == ST_SHIFT);
      SO       <= (state_nxt == ST_SHIFT) && head_nxt;
      latch    <= (state_nxt == ST_LATCH);
    end
  end

endmodule

// File: tb/tb_pi_so_shift_tx.sv
// Bench: MSB-first and LSB-first transmitters share one stimulus; a word-level model
// predicts acceptance and latch timing, and a negedge monitor scores what arrives.
module tb_pi_so_shift_tx;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] w;
    int           e0;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [W-1:0] din;
  logic         probe;
  logic         done;

  logic so_w [2];
  logic sov_w [2];
  logic lat_w [2];
  logic rdy_w [2];
  logic busy_w [2];

  always #5 clk = ~clk;

  pi_so_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .load(load), .din(din), .ready(rdy_w[0]),
    .SO(so_w[0]), .so_valid(sov_w[0]), .latch(lat_w[0]), .busy(busy_w[0])
  );

  pi_so_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .load(load), .din(din), .ready(rdy_w[1]),
    .SO(so_w[1]), .so_valid(sov_w[1]), .latch(lat_w[1]), .busy(busy_w[1])
  );

  // Reference model: a word is taken whenever load is high and the link is
  // free; the link is free again WIDTH+1 edges after an acceptance.
  exp_t q[$];
  int   cyc = 0;
  int   free_edge = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      free_edge = 0;
    end else if (load && cyc >= free_edge) begin
      q.push_back('{w: din, e0: cyc});
      free_edge = cyc + W + 1;
    end
  end

  function automatic logic [W-1:0] exp_seq(logic [W-1:0] w, bit msb);
    logic [W-1:0] s;
    for (int i = 0; i < W; i++) s[i] = msb ? w[W-1-i] : w[i];
    return s;
  endfunction

  // Monitor / scoreboard
  int           checks = 0;
  int           errors = 0;
  int           rd = 0;
  int           nb [2];
  logic [W-1:0] bits [2];
  logic [W-1:0] rx = '0;
  exp_t         e;
  bit           done_seen = 1'b0;

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cyc=%0d actual=%0h required=%0h", name, idx, cyc, act, exp);
    end
  endtask

  always @(negedge clk or posedge probe) begin
    if (probe || rst) begin
      for (int k = 0; k < 2; k++) begin
        chk("reset_outputs", k, 32'({so_w[k], sov_w[k], lat_w[k], busy_w[k], rdy_w[k]}), 32'b00001);
        nb[k]   = 0;
        bits[k] = '0;
      end
      rd = q.size();
    end else begin
      for (int k = 0; k < 2; k++)
        chk("ready", k, 32'(rdy_w[k]), 32'(cyc + 1 >= free_edge));
      if (lat_w[0] || lat_w[1]) begin
        chk("latch_expected", 0, 32'(rd < q.size()), 32'd1);
        if (rd < q.size()) begin
          e = q[rd];
          rd++;
          for (int k = 0; k < 2; k++) begin
            chk("latch_pair", k, 32'(lat_w[k]), 32'd1);
            chk("latch_time", k, 32'(cyc), 32'(e.e0 + W));
            chk("bit_count", k, 32'(nb[k]), 32'(W));
            chk("word_bits", k, 32'(bits[k]), 32'(exp_seq(e.w, k == 0)));
            chk("so_idle_in_latch", k, 32'({so_w[k], sov_w[k]}), 32'd0);
          end
          chk("rx_po", 0, 32'(rx), 32'(e.w));
        end
        for (int k = 0; k < 2; k++) begin
          nb[k]   = 0;
          bits[k] = '0;
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (sov_w[k]) begin
          if (nb[k] < W) bits[k][nb[k]] = so_w[k];
          nb[k]++;
        end
      end
      rx = {rx[W-2:0], so_w[0]};
      if (done && !done_seen) begin
        chk("all_words_latched", 0, 32'(rd), 32'(q.size()));
        done_seen = 1'b1;
      end
    end
  end

  // Stimulus
  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(logic [W-1:0] w);
    load = 1'b1;
    din  = w;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    load  = 1'b0;
    din   = '0;
    probe = 1'b0;
    done  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(2);

    send(8'hA5);
    idle(12);

    // back-to-back with load held: second word taken in the latch cycle
    load = 1'b1;
    din  = 8'h3C;
    @(negedge clk);
    din = 8'hC3;
    repeat (9) @(negedge clk);
    load = 1'b0;
    idle(12);

    // load while shifting is ignored
    send(8'h00);
    idle(2);
    load = 1'b1;
    din  = 8'hFF;
    idle(3);
    load = 1'b0;
    idle(12);

    // abort mid-word with an async reset between clock edges
    send(8'h81);
    idle(3);
    #1 rst = 1'b1;
    #1 probe = 1'b1;
    #1 probe = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    send(8'h7E);
    idle(12);

    send(8'h01);
    idle(12);

    repeat (400) begin
      load = ($urandom_range(0, 2) != 0);
      din  = W'($urandom);
      @(negedge clk);
    end
    load = 1'b0;
    idle(12);

    done = 1'b1;
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
